// File: rtl/rr_detect_ctrl.sv
// rr_detect_ctrl
//   Round-robin arbiter that lends one shared A->B sequence detector to
//   N_REQ requesters. The granted requester's A/B bits are steered onto the
//   detector inputs. The detector hit is routed back to the owner. A grant
//   held for MAX_CYC cycles without a hit is timed out. Every grant ends with
//   a one-cycle release that clears the detector.
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous active-high reset
//   req      per-requester request level
//   req_a    per-requester A stimulus
//   req_b    per-requester B stimulus
//   gnt      registered one-hot (or zero) grant
//   busy     high while a grant is held
//   det_a    A input to the shared detector (owner's req_a)
//   det_b    B input to the shared detector (owner's req_b)
//   det_clr  detector clear, active high
//   det_q    detector hit pulse
//   hit      one-cycle hit pulse to the owning requester
//   tmo      one-cycle timeout pulse
module rr_detect_ctrl #(
  parameter int N_REQ   = 4,
  parameter int MAX_CYC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_a,
  input  logic [N_REQ-1:0] req_b,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             det_a,
  output logic             det_b,
  output logic             det_clr,
  input  logic             det_q,
  output logic [N_REQ-1:0] hit,
  output logic             tmo
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    gidx;
  logic [IW-1:0]    last_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic [IW-1:0]    sel_idx;
  logic [7:0]       cnt;
  logic             own_req;
  logic             own_timeout;
  logic [N_REQ-1:0] gnt_nxt;
  logic [N_REQ-1:0] hit_nxt;
  logic             tmo_nxt;

  // Round-robin pick: scan starting one past the last owner and wrap.
  always_comb begin : rr_pick
    int unsigned   idx;
    logic [IW-1:0] cand;
    idx      = 0;
    cand     = '0;
    pick_vld = 1'b0;
    pick_idx = last_gnt;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx  = (32'(last_gnt) + k) % N_REQ;
      cand = IW'(idx);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign own_req     = req[gidx];
  assign own_timeout = (cnt == 8'(MAX_CYC - 1));

  // State register plus the registered outputs and bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gidx     <= '0;
      last_gnt <= IW'(N_REQ - 1);
      cnt      <= '0;
      gnt      <= '0;
      hit      <= '0;
      tmo      <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      hit   <= hit_nxt;
      tmo   <= tmo_nxt;
      if (state == IDLE && pick_vld) begin
        gidx <= pick_idx;
        cnt  <= '0;
      end else if (state == OWN) begin
        cnt <= cnt + 8'd1;
      end
      if (state == REL) begin
        last_gnt <= gidx;
      end
    end
  end

  // Next-state logic. In OWN the detector hit outranks a request drop,
  // which outranks the timeout; all three end the grant.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_vld) state_nxt = OWN;
      OWN:  if (det_q || !own_req || own_timeout) state_nxt = REL;
      REL:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy    = (state == OWN);
    det_a   = 1'b0;
    det_b   = 1'b0;
    // Clear is also driven during reset so the detector is held clear with us.
    det_clr = reset || (state == REL);
    if (state == OWN) begin
      det_a = req_a[gidx];
      det_b = req_b[gidx];
    end

    // The grant register is loaded with the index being picked on IDLE->OWN,
    // so gnt rises one edge after the request is seen.
    sel_idx = (state == IDLE) ? pick_idx : gidx;
    gnt_nxt = '0;
    if (state_nxt == OWN) begin
      gnt_nxt = N_REQ'(1) << sel_idx;
    end

    hit_nxt = '0;
    tmo_nxt = 1'b0;
    if (state == OWN) begin
      if (det_q) begin
        hit_nxt = N_REQ'(1) << gidx;
      end else if (own_req && own_timeout) begin
        tmo_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rr_detect_ctrl.sv
module tb_rr_detect_ctrl;
  localparam int N  = 4;
  localparam int MC = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, req_a, req_b;
  logic [N-1:0] gnt, hit;
  logic         busy, det_a, det_b, det_clr, det_q, tmo;

  logic         det_q_drv = 1'b0;
  logic         use_det   = 1'b0;
  logic         seen_a    = 1'b0;
  logic         det_q_mdl = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic         chk_en   = 1'b0;
  logic [N-1:0] gnt_prev = '0;

  always #5 clk = ~clk;

  rr_detect_ctrl #(.N_REQ(N), .MAX_CYC(MC)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .busy(busy), .det_a(det_a), .det_b(det_b), .det_clr(det_clr),
    .det_q(det_q), .hit(hit), .tmo(tmo)
  );

  // Behavioural shared detector: pulses when B follows A on the next cycle.
  always @(posedge clk) begin
    if (det_clr) begin
      seen_a    <= 1'b0;
      det_q_mdl <= 1'b0;
    end else begin
      det_q_mdl <= seen_a && det_b;
      seen_a    <= det_a;
    end
  end
  assign det_q = use_det ? det_q_mdl : det_q_drv;

  // Invariants checked every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (!$onehot0(gnt)) begin
        fails++; $display("FAIL onehot_gnt: gnt=%b must be onehot0", gnt);
      end
      tests++;
      if ((hit & ~gnt_prev) != '0) begin
        fails++; $display("FAIL hit_owner: hit=%b prev gnt=%b", hit, gnt_prev);
      end
      tests++;
      if ((hit != '0) && tmo) begin
        fails++; $display("FAIL hit_tmo_excl: hit=%b tmo=%b", hit, tmo);
      end
      tests++;
      if (busy !== (gnt != '0)) begin
        fails++; $display("FAIL busy_gnt: busy=%b gnt=%b", busy, gnt);
      end
    end
    gnt_prev = gnt;
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_grant(input string name);
    for (int w = 0; w < 12 && gnt == '0; w++) tick;
    tests++;
    if (gnt == '0) begin
      fails++; $display("FAIL %s_grant_timeout: gnt=%b required nonzero", name, gnt);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; req_a = '0; req_b = '0; det_q_drv = 1'b0; use_det = 1'b0;
    tick; tick;
    tests++;
    if (gnt !== '0 || hit !== '0 || tmo !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: gnt=%b hit=%b tmo=%b busy=%b required 0", gnt, hit, tmo, busy);
    end
    tests++;
    if (det_clr !== 1'b1) begin
      fails++; $display("FAIL reset_det_clr: det_clr=%b required 1", det_clr);
    end
    reset = 1'b0;
    tick;
    tests++;
    if (det_clr !== 1'b0 || busy !== 1'b0 || gnt !== '0) begin
      fails++; $display("FAIL post_reset_idle: det_clr=%b busy=%b gnt=%b required 0", det_clr, busy, gnt);
    end
    chk_en = 1'b1;
  endtask

  task automatic test_single;
    use_det = 1'b1;
    req = 4'b0001;
    tick;
    tests++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      fails++; $display("FAIL single_grant: gnt=%b busy=%b required 0001/1", gnt, busy);
    end
    req_a = 4'b0001; #1;
    tests++;
    if (det_a !== 1'b1 || det_b !== 1'b0) begin
      fails++; $display("FAIL single_mirror_a: det_a=%b det_b=%b required 1/0", det_a, det_b);
    end
    tick;
    req_a = '0; req_b = 4'b0001; #1;
    tests++;
    if (det_b !== 1'b1 || det_a !== 1'b0) begin
      fails++; $display("FAIL single_mirror_b: det_a=%b det_b=%b required 0/1", det_a, det_b);
    end
    tick;
    req_b = '0;
    tests++;
    if (hit !== '0 || gnt !== 4'b0001) begin
      fails++; $display("FAIL single_own3: hit=%b gnt=%b required 0000/0001", hit, gnt);
    end
    tick;
    req = '0;
    tests++;
    if (hit !== 4'b0001 || gnt !== '0 || det_clr !== 1'b1 || tmo !== 1'b0) begin
      fails++; $display("FAIL single_hit_rel: hit=%b gnt=%b det_clr=%b tmo=%b required 0001/0000/1/0", hit, gnt, det_clr, tmo);
    end
    tick;
    tests++;
    if (hit !== '0 || det_clr !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL single_idle: hit=%b det_clr=%b busy=%b required 0", hit, det_clr, busy);
    end
    use_det = 1'b0;
  endtask

  task automatic test_round_robin;
    int prev_cyc;
    logic [N-1:0] exp;
    prev_cyc = 0;
    reset = 1'b1; tick; reset = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("rr");
      exp = '0; exp[k % N] = 1'b1;
      tests++;
      if (gnt !== exp) begin
        fails++; $display("FAIL rr_order%0d: gnt=%b required %b", k, gnt, exp);
      end
      if (k > 0) begin
        tests++;
        if (cyc - prev_cyc != 4) begin
          fails++; $display("FAIL rr_spacing%0d: spacing=%0d required 4", k, cyc - prev_cyc);
        end
      end
      prev_cyc = cyc;
      tick;
      req[k % N] = 1'b0;
      tick;
      tests++;
      if (gnt !== '0 || det_clr !== 1'b1) begin
        fails++; $display("FAIL rr_rel%0d: gnt=%b det_clr=%b required 0000/1", k, gnt, det_clr);
      end
      req = 4'b1111;
      tick;
    end
    req = '0; tick; tick; tick;
  endtask

  task automatic test_timeout;
    int count;
    req = 4'b0100; req_a = '0; req_b = '0;
    wait_grant("tmo");
    count = 0;
    while (gnt == 4'b0100 && count < 20) begin
      count++;
      if (tmo !== 1'b0 || hit !== '0) begin
        tests++; fails++; $display("FAIL tmo_early: tmo=%b hit=%b required 0", tmo, hit);
      end
      tick;
    end
    tests++;
    if (count != MC) begin
      fails++; $display("FAIL tmo_hold: held=%0d required %0d", count, MC);
    end
    tests++;
    if (tmo !== 1'b1 || hit !== '0 || gnt !== '0) begin
      fails++; $display("FAIL tmo_pulse: tmo=%b hit=%b gnt=%b required 1/0000/0000", tmo, hit, gnt);
    end
    req = '0; tick;
    tests++;
    if (tmo !== 1'b0) begin
      fails++; $display("FAIL tmo_one_cycle: tmo=%b required 0", tmo);
    end
    tick;
  endtask

  task automatic test_simultaneous;
    req = 4'b0001;
    wait_grant("sim");
    for (int c = 1; c < MC; c++) tick;
    tests++;
    if (gnt !== 4'b0001) begin
      fails++; $display("FAIL sim_last_cycle: gnt=%b required 0001", gnt);
    end
    det_q_drv = 1'b1; req = '0;
    tick;
    det_q_drv = 1'b0;
    tests++;
    if (hit !== 4'b0001 || tmo !== 1'b0) begin
      fails++; $display("FAIL sim_priority: hit=%b tmo=%b required 0001/0", hit, tmo);
    end
    tick; tick;
  endtask

  task automatic test_reset_mid;
    req = 4'b0010;
    wait_grant("rst_pre");
    req = '0; tick; tick;
    req = 4'b0010;
    wait_grant("rst_mid");
    tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tests++;
    if (gnt !== '0 || hit !== '0 || tmo !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid_drop: gnt=%b hit=%b tmo=%b busy=%b required 0", gnt, hit, tmo, busy);
    end
    req = 4'b1010;
    tick;
    tests++;
    if (gnt !== 4'b0010) begin
      fails++; $display("FAIL rst_mid_ptr: gnt=%b required 0010", gnt);
    end
    req = '0; tick; tick; tick;
  endtask

  task automatic test_random;
    int owner, own_n, rel_owner, ptr, c;
    logic releasing, found;
    logic [N-1:0] egnt, ehit;
    logic etmo, ea, eb, eclr;
    reset = 1'b1; tick; reset = 1'b0;
    owner = -1; own_n = 0; rel_owner = 0; ptr = N - 1; releasing = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      req_a     = N'($urandom);
      req_b     = N'($urandom);
      det_q_drv = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      #1;
      ea   = (owner >= 0) ? req_a[owner] : 1'b0;
      eb   = (owner >= 0) ? req_b[owner] : 1'b0;
      eclr = reset || releasing;
      tests++;
      if (det_a !== ea || det_b !== eb || det_clr !== eclr) begin
        fails++; $display("FAIL rnd_comb@%0d: a/b/clr=%b%b%b required %b%b%b", i, det_a, det_b, det_clr, ea, eb, eclr);
      end
      ehit = '0; etmo = 1'b0;
      if (reset) begin
        owner = -1; releasing = 1'b0; ptr = N - 1;
      end else if (releasing) begin
        ptr = rel_owner; releasing = 1'b0;
      end else if (owner >= 0) begin
        own_n++;
        if (det_q_drv) ehit[owner] = 1'b1;
        else if (req[owner] && own_n == MC) etmo = 1'b1;
        if (det_q_drv || !req[owner] || own_n == MC) begin
          rel_owner = owner; owner = -1; releasing = 1'b1;
        end
      end else begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (ptr + k) % N;
          if (!found && req[c]) begin found = 1'b1; owner = c; own_n = 0; end
        end
      end
      egnt = '0;
      if (owner >= 0) egnt[owner] = 1'b1;
      tick;
      tests++;
      if (gnt !== egnt || hit !== ehit || tmo !== etmo) begin
        fails++; $display("FAIL rnd_out@%0d: gnt=%b hit=%b tmo=%b required %b %b %b", i, gnt, hit, tmo, egnt, ehit, etmo);
      end
    end
    reset = 1'b0; req = '0; det_q_drv = 1'b0; tick; tick; tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_timeout;
    test_simultaneous;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
